instr_word_encoder: RTL and testbench

Inverse of the instruction-group decoders. Accepts one decoded instruction (group, opcode, register indices, pair flags, immediate) over a valid/ready handshake, re-encodes it into Jolt160 instruction words, and writes the result big-endian, one byte at a time, to a byte-wide memory write port with a request/acknowledge handshake. An internal write address auto-increments across instructions. Used by the debug/loader path to patch code memory, and by the bench as the reference encoder for decoder round-trip checks.

---
 rtl/instr_word_encoder.sv | 137 +++++++++++++
 tb/tb_instr_word_encoder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/instr_word_encoder.sv
// instr_word_encoder: re-encodes one decoded instruction into Jolt160 words and
// writes them big-endian, one byte per acknowledged write, at an auto-incrementing address.
module instr_word_encoder #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  base_load,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_group,
    input  logic [5:0]            req_opcode,
    input  logic [3:0]            req_ra,
    input  logic                  req_ra_pair,
    input  logic [3:0]            req_rb,
    input  logic                  req_rb_pair,
    input  logic [2:0]            req_rc,
    input  logic [15:0]           req_imm,
    output logic                  mem_wr_req,
    input  logic                  mem_wr_ack,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_data,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] cur_addr
);
    typedef enum logic [1:0] {IDLE, CHECK, WRITE, FIN} state_t;
    state_t state, state_nxt;
    logic [2:0]  grp;
    logic [5:0]  opc;
    logic [3:0]  ra, rb;
    logic        ra_pair, rb_pair;
    logic [2:0]  rc;
    logic [15:0] imm;
    logic [31:0] word, word_nxt;
    logic [1:0]  idx;
    logic        is_g5;
    logic        accept, op_ok, pair_ok, valid, last_byte;
    logic [3:0]  ra_f, rb_f;
    assign accept    = (state == IDLE) && req_valid;
    assign ra_f      = ra_pair ? {ra[2:0], 1'b0} : ra;
    assign rb_f      = rb_pair ? {rb[2:0], 1'b0} : rb;
    assign last_byte = idx == (is_g5 ? 2'd3 : 2'd1);
    // Group 4 has no register field, so its ra pair flag carries no meaning.
    assign pair_ok = !(ra_pair && ra[3] && grp != 3'd4) && !(rb_pair && rb[3] && grp == 3'd2);
    assign valid   = op_ok && pair_ok;
    always_comb begin
        op_ok    = 1'b0;
        word_nxt = 32'h0;
        case (grp)
            3'd1: begin
                op_ok    = opc[5:3] == 3'd0;
                word_nxt = {1'b0, opc[2:0], ra_f, imm[7:0], 16'h0};
            end
            3'd2: begin
                op_ok    = 1'b1;
                word_nxt = {2'b10, opc, ra_f, rb_f, 16'h0};
            end
            3'd3: begin
                op_ok    = opc[5:2] == 4'd0;
                word_nxt = {4'b1100, opc[1:0], ra_f, rb[2:0], rc, 16'h0};
            end
            3'd4: begin
                op_ok    = opc[5:4] == 2'd0;
                word_nxt = {4'b1101, opc[3:0], imm[7:0], 16'h0};
            end
            3'd5: begin
                op_ok    = opc[5:3] == 3'd0;
                word_nxt = {6'b111000, opc[2:0], ra_f, rb[2:0], imm};
            end
            default: begin
                op_ok    = 1'b0;
                word_nxt = 32'h0;
            end
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? CHECK : IDLE;
            CHECK:   state_nxt = valid ? WRITE : IDLE;
            WRITE:   state_nxt = (mem_wr_ack && last_byte) ? FIN : WRITE;
            default: state_nxt = IDLE;
        endcase
    end
    always_comb begin
        req_ready  = state == IDLE;
        mem_wr_req = state == WRITE;
        mem_data   = (state == WRITE) ? word[8*(3-int'(idx)) +: 8] : 8'h0;
        mem_addr   = cur_addr;
        done       = state == FIN;
        err        = (state == CHECK) && !valid;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr <= '0;
            grp      <= '0;
            opc      <= '0;
            ra       <= '0;
            rb       <= '0;
            ra_pair  <= 1'b0;
            rb_pair  <= 1'b0;
            rc       <= '0;
            imm      <= '0;
            word     <= '0;
            idx      <= '0;
            is_g5    <= 1'b0;
        end else begin
            // Base is loaded before the accepted instruction is written, so a coincident load applies to it.
            if (state == IDLE && base_load) cur_addr <= base_addr;
            if (accept) begin
                grp     <= req_group;
                opc     <= req_opcode;
                ra      <= req_ra;
                rb      <= req_rb;
                ra_pair <= req_ra_pair;
                rb_pair <= req_rb_pair;
                rc      <= req_rc;
                imm     <= req_imm;
            end
            if (state == CHECK) begin
                word  <= word_nxt;
                idx   <= '0;
                is_g5 <= grp == 3'd5;
            end
            if (state == WRITE && mem_wr_ack) begin
                cur_addr <= cur_addr + 1'b1;
                idx      <= idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instr_word_encoder.sv
// tb_instr_word_encoder: directed and random instructions checked against an
// arithmetic encoding model and a byte-by-byte memory write timeline.
module tb_instr_word_encoder;
    localparam int AW = 16;
    logic          clk = 1'b0;
    logic          rst;
    logic          base_load;
    logic [AW-1:0] base_addr;
    logic          req_valid, req_ready;
    logic [2:0]    req_group;
    logic [5:0]    req_opcode;
    logic [3:0]    req_ra, req_rb;
    logic          req_ra_pair, req_rb_pair;
    logic [2:0]    req_rc;
    logic [15:0]   req_imm;
    logic          mem_wr_req, mem_wr_ack;
    logic [AW-1:0] mem_addr, cur_addr;
    logic [7:0]    mem_data;
    logic          done, err;
    int            n_tests = 0;
    int            n_fail = 0;
    logic [15:0]   maddr;

    instr_word_encoder #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .base_load(base_load), .base_addr(base_addr),
        .req_valid(req_valid), .req_ready(req_ready), .req_group(req_group),
        .req_opcode(req_opcode), .req_ra(req_ra), .req_ra_pair(req_ra_pair),
        .req_rb(req_rb), .req_rb_pair(req_rb_pair), .req_rc(req_rc), .req_imm(req_imm),
        .mem_wr_req(mem_wr_req), .mem_wr_ack(mem_wr_ack), .mem_addr(mem_addr),
        .mem_data(mem_data), .done(done), .err(err), .cur_addr(cur_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Encoding computed from field positions with plain arithmetic; bytes left-justified in w.
    function automatic void model(input int g, op, ra, rap, rb, rbp, rc, imm,
                                  output logic [31:0] w, output int n, output bit ok);
        int raf, rbf, hi, wid;
        wid = g == 1 ? 3 : g == 2 ? 6 : g == 3 ? 2 : g == 4 ? 4 : g == 5 ? 3 : 0;
        raf = rap != 0 ? (ra % 8) * 2 : ra;
        rbf = rbp != 0 ? (rb % 8) * 2 : rb;
        ok = g >= 1 && g <= 5 && op < (1 << wid) && !(rap != 0 && ra >= 8 && g != 4)
             && !(g == 2 && rbp != 0 && rb >= 8);
        n = g == 5 ? 4 : 2;
        case (g)
            1: hi = op * 4096 + raf * 256 + imm % 256;
            2: hi = 32768 + op * 256 + raf * 16 + rbf;
            3: hi = 'hC000 + op * 1024 + raf * 64 + (rb % 8) * 8 + rc;
            4: hi = 'hD000 + op * 256 + imm % 256;
            5: hi = 'hE000 + op * 128 + raf * 8 + rb % 8;
            default: hi = 0;
        endcase
        w = {hi[15:0], g == 5 ? imm[15:0] : 16'h0};
    endfunction

    task automatic run(input int g, op, ra, rap, rb, rbp, rc, imm,
                       input int st_lo, st_hi, input bit noise, input bit do_base,
                       input logic [15:0] base);
        logic [31:0] w;
        int n, k, stall;
        bit ok;
        model(g, op, ra, rap, rb, rbp, rc, imm, w, n, ok);
        @(negedge clk);
        chk("ready_idle", req_ready, 1);
        req_valid = 1; req_group = g[2:0]; req_opcode = op[5:0]; req_ra = ra[3:0];
        req_ra_pair = rap[0]; req_rb = rb[3:0]; req_rb_pair = rbp[0]; req_rc = rc[2:0];
        req_imm = imm[15:0]; base_load = do_base; base_addr = base;
        if (do_base) maddr = base;
        @(negedge clk);
        req_valid = 0; base_load = 0; base_addr = 16'($urandom);
        req_group = 3'($urandom); req_opcode = 6'($urandom); req_ra = 4'($urandom);
        req_imm = 16'($urandom); mem_wr_ack = 0;
        chk("err_check", err, !ok);
        chk("wr_req_check", mem_wr_req, 0);
        if (!ok) begin
            @(negedge clk);
            chk("ready_after_err", req_ready, 1);
            chk("err_pulse_end", err, 0);
            chk("addr_after_err", cur_addr, maddr);
            chk("no_wr_after_err", mem_wr_req, 0);
            return;
        end
        k = 0;
        stall = $urandom_range(st_hi, st_lo);
        while (k < n) begin
            @(negedge clk);
            chk("wr_req", mem_wr_req, 1);
            chk("mem_addr", mem_addr, maddr);
            chk("mem_data", mem_data, w[31-8*k -: 8]);
            if (noise) begin
                req_valid = 1'($urandom); base_load = 1'($urandom); base_addr = 16'($urandom);
            end
            if (stall > 0) begin
                mem_wr_ack = 0;
                stall--;
            end else begin
                mem_wr_ack = 1;
                k++;
                maddr++;
                stall = $urandom_range(st_hi, st_lo);
            end
        end
        @(negedge clk);
        mem_wr_ack = 0; req_valid = 0; base_load = 0;
        chk("done", done, 1);
        chk("wr_req_fin", mem_wr_req, 0);
        chk("cur_addr_fin", cur_addr, maddr);
        @(negedge clk);
        chk("ready_after_done", req_ready, 1);
        chk("done_pulse_end", done, 0);
    endtask

    initial begin
        rst = 1; base_load = 0; base_addr = 0; req_valid = 0; req_group = 0; req_opcode = 0;
        req_ra = 0; req_ra_pair = 0; req_rb = 0; req_rb_pair = 0; req_rc = 0; req_imm = 0;
        mem_wr_ack = 0; maddr = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_wr_req", mem_wr_req, 0);
        chk("rst_data", mem_data, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_cur_addr", cur_addr, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 0;
        @(negedge clk);
        base_load = 1; base_addr = 16'h0100; maddr = 16'h0100;
        @(negedge clk);
        base_load = 0;
        chk("base_load", cur_addr, 16'h0100);
        run(1, 3, 5, 0, 0, 0, 0, 'hA7, 0, 0, 0, 0, 0);
        chk("g1_end_addr", cur_addr, 16'h0102);
        run(2, 'h2A, 3, 1, 'hF, 0, 0, 0, 0, 0, 0, 0, 0);
        run(5, 5, 9, 0, 2, 0, 0, 'hBEEF, 0, 0, 0, 0, 0);
        run(3, 2, 4, 0, 1, 0, 7, 0, 3, 3, 1, 0, 0);
        run(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        run(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run(2, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run(4, 1, 0, 0, 0, 0, 0, 'h22, 0, 0, 0, 1, 16'hFFFF);
        chk("wrap_addr", cur_addr, 16'h0001);
        // Abandon an instruction mid-write with an asynchronous reset.
        @(negedge clk);
        req_valid = 1; req_group = 1; req_opcode = 1; req_ra = 1; req_ra_pair = 0; req_imm = 1;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        chk("pre_rst_wr_req", mem_wr_req, 1);
        #1 rst = 1;
        #1;
        chk("rst_mid_wr_req", mem_wr_req, 0);
        chk("rst_mid_cur_addr", cur_addr, 0);
        chk("rst_mid_ready", req_ready, 1);
        @(negedge clk);
        rst = 0; maddr = 0;
        @(negedge clk);
        chk("post_rst_done", done, 0);
        chk("post_rst_err", err, 0);
        for (int i = 0; i < 60; i++) begin
            int g, op;
            g = $urandom_range(9, 0) < 8 ? $urandom_range(5, 1) : $urandom_range(7, 0);
            op = $urandom_range(3, 0) == 0 ? $urandom_range(63, 0) : $urandom_range(7, 0);
            run(g, op, $urandom_range(15, 0), $urandom_range(1, 0), $urandom_range(15, 0),
                $urandom_range(1, 0), $urandom_range(7, 0), $urandom_range(65535, 0),
                0, $urandom_range(2, 0), 1'($urandom), 1'($urandom), 16'($urandom));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
